// File: rtl/memrequest_responder.sv
// memrequest_responder
//   Target side of the UberDDR3 memrequest interface. Behaves like the DDR3
//   controller at cycle level. It can stand in for the controller in
//   simulation, or act as a BRAM-backed fallback on boards without DRAM.
//   Every accepted request produces exactly one completion. Completions come
//   back in order, LATENCY cycles after acceptance. Backpressure comes from
//   an outstanding-request limit and from periodic refresh stalls.
//
// Ports
//   clk_dram_ctrl            controller clock
//   rst_dram_ctrl_n          asynchronous active-low reset
//   memrequest_addr          request word address (low MEM_WORDS_LOG2 bits used)
//   memrequest_en            request strobe
//   memrequest_write_data    write data
//   memrequest_write_enable  1 = write, 0 = read
//   memrequest_resp_data     read data; zero for writes and when no completion
//   memrequest_complete      one-cycle pulse per accepted request
//   memrequest_busy          requests are not accepted this cycle
//   outstanding_count        accepted requests whose completion has not been issued
//   protocol_error           sticky; set by en while busy
module memrequest_responder #(
  parameter int ADDR_WIDTH      = 24,
  parameter int DATA_WIDTH      = 128,
  parameter int MEM_WORDS_LOG2  = 12,
  parameter int LATENCY         = 8,
  parameter int MAX_OUTSTANDING = 6,
  parameter int REFRESH_PERIOD  = 1024,
  parameter int REFRESH_CYCLES  = 16
) (
  input  logic                                       clk_dram_ctrl,
  input  logic                                       rst_dram_ctrl_n,
  input  logic [ADDR_WIDTH-1:0]                      memrequest_addr,
  input  logic                                       memrequest_en,
  input  logic [DATA_WIDTH-1:0]                      memrequest_write_data,
  input  logic                                       memrequest_write_enable,
  output logic [DATA_WIDTH-1:0]                      memrequest_resp_data,
  output logic                                       memrequest_complete,
  output logic                                       memrequest_busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_count,
  output logic                                       protocol_error
);

  localparam int OCNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int RCNT_MAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
  localparam int RCNT_W  = $clog2(RCNT_MAX + 1);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_REFRESH} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         w_busy;
  logic                         w_accept;
  logic                         w_issue;
  logic [RCNT_W-1:0]            r_refresh_cnt;
  logic [MEM_WORDS_LOG2-1:0]    w_idx;
  logic                         w_unused_addr_hi;

  logic [DATA_WIDTH-1:0]        r_mem [2**MEM_WORDS_LOG2];
  logic [DATA_WIDTH-1:0]        r_rd_word;
  logic [LATENCY-1:0]           r_vld;
  logic                         r_rd_p0;
  logic [DATA_WIDTH-1:0]        r_data [1:LATENCY-1];

  // Upper address bits alias onto the array and are deliberately dropped.
  assign w_idx            = memrequest_addr[MEM_WORDS_LOG2-1:0];
  assign w_unused_addr_hi = ^memrequest_addr[ADDR_WIDTH-1:MEM_WORDS_LOG2];

  // ---- Control FSM ----
  always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
    if (!rst_dram_ctrl_n) r_state <= ST_INIT;
    else                  r_state <= w_state_nxt;
  end

  // busy comes only from registered state, so it never loops back on en.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    case (r_state)
      ST_INIT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_busy = (outstanding_count == OCNT_W'(MAX_OUTSTANDING));
        if (r_refresh_cnt == RCNT_W'(REFRESH_PERIOD - 1)) w_state_nxt = ST_REFRESH;
      end
      ST_REFRESH: begin
        if (r_refresh_cnt == RCNT_W'(REFRESH_CYCLES - 1)) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // The same counter times RUN intervals and REFRESH stalls. It restarts on every state change.
  always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
    if (!rst_dram_ctrl_n)              r_refresh_cnt <= '0;
    else if (w_state_nxt != r_state)   r_refresh_cnt <= '0;
    else if (r_state != ST_INIT)       r_refresh_cnt <= r_refresh_cnt + RCNT_W'(1);
  end

  assign memrequest_busy = w_busy;
  assign w_accept        = memrequest_en && !w_busy;
  // The completion pulse is registered out of the next-to-last stage. The
  // request leaves the count on that same edge, so a slot frees up in the
  // same cycle that complete is visible.
  assign w_issue         = r_vld[LATENCY-2];

  always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
    if (!rst_dram_ctrl_n) begin
      outstanding_count <= '0;
      protocol_error    <= 1'b0;
    end else begin
      case ({w_accept, w_issue})
        2'b10:   outstanding_count <= outstanding_count + OCNT_W'(1);
        2'b01:   outstanding_count <= outstanding_count - OCNT_W'(1);
        default: outstanding_count <= outstanding_count;
      endcase
      if (memrequest_en && w_busy) protocol_error <= 1'b1;
    end
  end

  // ---- Backing array (no reset; contents survive reset) ----
  // The read is registered here, so its data joins the pipeline one stage
  // late. That is why LATENCY must be at least 2.
  always_ff @(posedge clk_dram_ctrl) begin
    if (w_accept) begin
      if (memrequest_write_enable) r_mem[w_idx] <= memrequest_write_data;
      else                         r_rd_word    <= r_mem[w_idx];
    end
  end

  // ---- Completion pipeline: stage p0 carries valid/read flag, data joins at stage 1 ----
  always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
    if (!rst_dram_ctrl_n) begin
      r_vld   <= '0;
      r_rd_p0 <= 1'b0;
      for (int k = 1; k < LATENCY; k++) r_data[k] <= '0;
    end else begin
      r_vld     <= {r_vld[LATENCY-2:0], w_accept};
      r_rd_p0   <= w_accept && !memrequest_write_enable;
      // Writes and bubbles carry zero, so resp_data is zero outside read completions.
      r_data[1] <= r_rd_p0 ? r_rd_word : '0;
      for (int k = 2; k < LATENCY; k++) r_data[k] <= r_data[k-1];
    end
  end

  assign memrequest_complete  = r_vld[LATENCY-1];
  assign memrequest_resp_data = r_data[LATENCY-1];

endmodule
